// File: rtl/rf_sched_pkg.sv
// Shared definitions for the register-file writeback scheduler.
//   XLEN       : data width of the register file
//   REG_ADDR_W : register address width
//   NUM_REGS   : number of architectural registers (x0 is hardwired zero)
//   grant_e    : arbiter grant identity, also used as the last-grant state
package rf_sched_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;

   typedef enum logic {
      GNT_ALU = 1'b0,
      GNT_LSU = 1'b1
   } grant_e;

endpackage

// File: rtl/wb_rr_arbiter2.sv
// Two-way round-robin arbiter for the register-file write port.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_alu, req_lsu   : writeback request valids
//   gnt_alu, gnt_lsu   : combinational one-hot (or zero) grants
// The last granted requester loses the next tie. Reset leaves last_grant at
// LSU so the ALU wins the first tie.
module wb_rr_arbiter2
   import rf_sched_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req_alu,
   input  logic req_lsu,
   output logic gnt_alu,
   output logic gnt_lsu
);

   grant_e last_grant_q;

   always_comb begin
      gnt_alu = req_alu && (!req_lsu || (last_grant_q == GNT_LSU));
      gnt_lsu = req_lsu && (!req_alu || (last_grant_q == GNT_ALU));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= GNT_LSU;
      end else if (gnt_alu) begin
         last_grant_q <= GNT_ALU;
      end else if (gnt_lsu) begin
         last_grant_q <= GNT_LSU;
      end
   end

endmodule

// File: rtl/regfile_scheduler.sv
// Register-file write scheduler: issue scoreboard plus ALU/LSU writeback
// arbitration onto a single registered write port.
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   issue_valid/rd/rs1/rs2, issue_stall : decode issue and hazard stall
//   alu_valid/rd/wd, alu_ready          : ALU writeback handshake
//   lsu_valid/rd/wd, lsu_ready          : load-unit writeback handshake
//   rf_wen/rf_a3/rf_wd                  : registered register-file write port
//   busy                                : per-register pending-write scoreboard
//   wb_err                              : sticky writeback-to-idle-register flag
module regfile_scheduler
   import rf_sched_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic [REG_ADDR_W-1:0] issue_rs1,
   input  logic [REG_ADDR_W-1:0] issue_rs2,
   output logic                  issue_stall,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_wd,
   output logic                  alu_ready,
   input  logic                  lsu_valid,
   input  logic [REG_ADDR_W-1:0] lsu_rd,
   input  logic [XLEN-1:0]       lsu_wd,
   output logic                  lsu_ready,
   output logic                  rf_wen,
   output logic [REG_ADDR_W-1:0] rf_a3,
   output logic [XLEN-1:0]       rf_wd,
   output logic [NUM_REGS-1:0]   busy,
   output logic                  wb_err
);

   logic [NUM_REGS-1:0]   busy_q, busy_d;
   logic                  rf_wen_q, rf_wen_d;
   logic [REG_ADDR_W-1:0] rf_a3_q, rf_a3_d;
   logic [XLEN-1:0]       rf_wd_q, rf_wd_d;
   logic                  wb_err_q, wb_err_d;

   logic                  issue_accept;
   logic                  alu_xfer, lsu_xfer, wb_xfer;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic [XLEN-1:0]       wb_wd;

   wb_rr_arbiter2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_alu (alu_valid),
      .req_lsu (lsu_valid),
      .gnt_alu (alu_ready),
      .gnt_lsu (lsu_ready)
   );

   // Stall looks only at registered busy: a writeback clearing a bit this
   // cycle does not release the stall until the next cycle.
   always_comb begin
      issue_stall  = issue_valid &&
                     (busy_q[issue_rs1] || busy_q[issue_rs2] || busy_q[issue_rd]);
      issue_accept = issue_valid && !issue_stall;
   end

   always_comb begin
      alu_xfer = alu_valid && alu_ready;
      lsu_xfer = lsu_valid && lsu_ready;
      wb_xfer  = alu_xfer || lsu_xfer;
      wb_rd    = lsu_xfer ? lsu_rd : alu_rd;
      wb_wd    = lsu_xfer ? lsu_wd : alu_wd;
   end

   always_comb begin
      busy_d   = busy_q;
      rf_wen_d = 1'b0;
      rf_a3_d  = rf_a3_q;
      rf_wd_d  = rf_wd_q;
      wb_err_d = wb_err_q;

      // Writes to x0 are accepted but produce no port write and no error.
      if (wb_xfer && (wb_rd != '0)) begin
         rf_wen_d      = 1'b1;
         rf_a3_d       = wb_rd;
         rf_wd_d       = wb_wd;
         busy_d[wb_rd] = 1'b0;
         if (!busy_q[wb_rd]) begin
            wb_err_d = 1'b1;
         end
      end

      // Applied after the clear so a same-cycle issue keeps the bit set.
      if (issue_accept && (issue_rd != '0)) begin
         busy_d[issue_rd] = 1'b1;
      end

      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= '0;
         rf_wen_q <= 1'b0;
         rf_a3_q  <= '0;
         rf_wd_q  <= '0;
         wb_err_q <= 1'b0;
      end else begin
         busy_q   <= busy_d;
         rf_wen_q <= rf_wen_d;
         rf_a3_q  <= rf_a3_d;
         rf_wd_q  <= rf_wd_d;
         wb_err_q <= wb_err_d;
      end
   end

   always_comb begin
      busy   = busy_q;
      rf_wen = rf_wen_q;
      rf_a3  = rf_a3_q;
      rf_wd  = rf_wd_q;
      wb_err = wb_err_q;
   end

endmodule

// File: tb/tb_regfile_scheduler.sv
module tb_regfile_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid;
   logic [4:0]  issue_rd, issue_rs1, issue_rs2;
   logic        issue_stall;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_wd;
   logic        alu_ready;
   logic        lsu_valid;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_wd;
   logic        lsu_ready;
   logic        rf_wen;
   logic [4:0]  rf_a3;
   logic [31:0] rf_wd;
   logic [31:0] busy;
   logic        wb_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   regfile_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_rs1   (issue_rs1),
      .issue_rs2   (issue_rs2),
      .issue_stall (issue_stall),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_wd      (alu_wd),
      .alu_ready   (alu_ready),
      .lsu_valid   (lsu_valid),
      .lsu_rd      (lsu_rd),
      .lsu_wd      (lsu_wd),
      .lsu_ready   (lsu_ready),
      .rf_wen      (rf_wen),
      .rf_a3       (rf_a3),
      .rf_wd       (rf_wd),
      .busy        (busy),
      .wb_err      (wb_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
      alu_valid = 1'b0; alu_rd = '0; alu_wd = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_wd = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      alu_valid = 1'b1; lsu_valid = 1'b1;
      issue_valid = 1'b1; issue_rd = 5'd5; issue_rs1 = 5'd6;
      #1;
      n_checks++; if (busy !== 32'h0) begin n_errors++; $display("FAIL reset_busy got %h want 0", busy); end
      n_checks++; if (rf_wen !== 1'b0) begin n_errors++; $display("FAIL reset_wen got %b want 0", rf_wen); end
      n_checks++; if (rf_a3 !== 5'd0) begin n_errors++; $display("FAIL reset_a3 got %0d want 0", rf_a3); end
      n_checks++; if (rf_wd !== 32'h0) begin n_errors++; $display("FAIL reset_wd got %h want 0", rf_wd); end
      n_checks++; if (wb_err !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b want 0", wb_err); end
      n_checks++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
         n_errors++; $display("FAIL reset_tie got alu=%b lsu=%b want alu=1 lsu=0", alu_ready, lsu_ready);
      end
      n_checks++; if (issue_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got %b want 0", issue_stall); end
      tick();
      n_checks++; if (rf_wen !== 1'b0 || busy !== 32'h0) begin
         n_errors++; $display("FAIL reset_hold got wen=%b busy=%h want 0/0", rf_wen, busy);
      end
      do_reset();
   endtask

   task automatic test_raw_stall();
      do_reset();
      issue_valid = 1'b1; issue_rd = 5'd5; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
      #1;
      n_checks++; if (issue_stall !== 1'b0) begin n_errors++; $display("FAIL raw_first_stall got %b want 0", issue_stall); end
      tick();
      n_checks++; if (busy !== 32'h20) begin n_errors++; $display("FAIL raw_busy5 got %h want 00000020", busy); end
      issue_rd = 5'd6; issue_rs1 = 5'd5;
      alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
      #1;
      n_checks++; if (issue_stall !== 1'b1) begin n_errors++; $display("FAIL raw_stall got %b want 1", issue_stall); end
      n_checks++; if (alu_ready !== 1'b1) begin n_errors++; $display("FAIL raw_alu_ready got %b want 1", alu_ready); end
      tick();
      alu_valid = 1'b0;
      #1;
      n_checks++; if (rf_wen !== 1'b1 || rf_a3 !== 5'd5 || rf_wd !== 32'hDEADBEEF) begin
         n_errors++; $display("FAIL raw_write got wen=%b a3=%0d wd=%h want 1/5/deadbeef", rf_wen, rf_a3, rf_wd);
      end
      n_checks++; if (issue_stall !== 1'b0) begin n_errors++; $display("FAIL raw_release got %b want 0", issue_stall); end
      issue_valid = 1'b0;
      tick();
      n_checks++; if (rf_wen !== 1'b0) begin n_errors++; $display("FAIL raw_wen_drop got %b want 0", rf_wen); end
   endtask

   task automatic test_tie_rr();
      logic [4:0] want_rd;
      do_reset();
      alu_valid = 1'b1; alu_rd = 5'd1; alu_wd = 32'h1111_0001;
      lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_wd = 32'h2222_0002;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++; if (alu_ready !== (i % 2 == 0) || lsu_ready !== (i % 2 == 1)) begin
            n_errors++; $display("FAIL tie_grant%0d got alu=%b lsu=%b want alu=%b", i, alu_ready, lsu_ready, i % 2 == 0);
         end
         want_rd = (i % 2 == 0) ? 5'd1 : 5'd2;
         tick();
         n_checks++; if (rf_wen !== 1'b1 || rf_a3 !== want_rd) begin
            n_errors++; $display("FAIL tie_a3_%0d got wen=%b a3=%0d want 1/%0d", i, rf_wen, rf_a3, want_rd);
         end
      end
      idle_inputs();
   endtask

   task automatic test_set_wins();
      do_reset();
      issue_valid = 1'b1; issue_rd = 5'd7;
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = 32'h0000_0777;
      #1;
      n_checks++; if (lsu_ready !== 1'b1 || issue_stall !== 1'b0) begin
         n_errors++; $display("FAIL setwin_comb got ready=%b stall=%b want 1/0", lsu_ready, issue_stall);
      end
      tick();
      idle_inputs();
      n_checks++; if (busy !== 32'h80) begin n_errors++; $display("FAIL setwin_busy got %h want 00000080", busy); end
      n_checks++; if (rf_wen !== 1'b1 || rf_a3 !== 5'd7) begin
         n_errors++; $display("FAIL setwin_write got wen=%b a3=%0d want 1/7", rf_wen, rf_a3);
      end
   endtask

   task automatic test_rd0();
      do_reset();
      issue_valid = 1'b1; issue_rd = 5'd3;
      tick();
      idle_inputs();
      alu_valid = 1'b1; alu_rd = 5'd0; alu_wd = 32'h1234;
      #1;
      n_checks++; if (alu_ready !== 1'b1) begin n_errors++; $display("FAIL rd0_ready got %b want 1", alu_ready); end
      tick();
      idle_inputs();
      n_checks++; if (rf_wen !== 1'b0) begin n_errors++; $display("FAIL rd0_wen got %b want 0", rf_wen); end
      n_checks++; if (busy !== 32'h8) begin n_errors++; $display("FAIL rd0_busy got %h want 00000008", busy); end
      n_checks++; if (wb_err !== 1'b0) begin n_errors++; $display("FAIL rd0_err got %b want 0", wb_err); end
   endtask

   task automatic test_wb_err();
      do_reset();
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_wd = 32'hCAFE_0009;
      tick();
      idle_inputs();
      n_checks++; if (rf_wen !== 1'b1 || rf_a3 !== 5'd9 || rf_wd !== 32'hCAFE_0009) begin
         n_errors++; $display("FAIL err_write got wen=%b a3=%0d wd=%h want 1/9/cafe0009", rf_wen, rf_a3, rf_wd);
      end
      n_checks++; if (wb_err !== 1'b1) begin n_errors++; $display("FAIL err_set got %b want 1", wb_err); end
      repeat (5) tick();
      n_checks++; if (wb_err !== 1'b1) begin n_errors++; $display("FAIL err_sticky got %b want 1", wb_err); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (wb_err !== 1'b0) begin n_errors++; $display("FAIL err_clear got %b want 0", wb_err); end
      do_reset();
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int r = 8; r < 12; r++) begin
         issue_valid = 1'b1; issue_rd = 5'(r);
         tick();
      end
      idle_inputs();
      n_checks++; if (busy !== 32'h0000_0F00) begin n_errors++; $display("FAIL ar_busy got %h want 00000f00", busy); end
      alu_valid = 1'b1; alu_rd = 5'd8; alu_wd = 32'h8888;
      tick();
      alu_rd = 5'd9; alu_wd = 32'h9999;
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++; if (busy !== 32'h0 || rf_wen !== 1'b0) begin
         n_errors++; $display("FAIL ar_clear got busy=%h wen=%b want 0/0", busy, rf_wen);
      end
      idle_inputs();
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++; if (rf_wen !== 1'b0 || busy !== 32'h0) begin
         n_errors++; $display("FAIL ar_after got wen=%b busy=%h want 0/0", rf_wen, busy);
      end
   endtask

   // Reference model: scoreboard as a set of pending registers, round-robin
   // remembered as the identity of the last winner.
   task automatic test_random();
      bit          pend[32];
      bit          lsu_won_last;
      bit          err_m;
      bit          e_wen, e_stall, g_alu, g_lsu, alu_done, lsu_done;
      logic [4:0]  e_a3, w_rd;
      logic [31:0] e_wd, e_busy;
      do_reset();
      for (int k = 0; k < 32; k++) pend[k] = 1'b0;
      lsu_won_last = 1'b1; err_m = 1'b0; alu_done = 1'b1; lsu_done = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if (alu_done || !alu_valid) begin
            alu_valid = ($urandom % 3) != 0; alu_rd = 5'($urandom_range(0, 7)); alu_wd = $urandom;
         end
         if (lsu_done || !lsu_valid) begin
            lsu_valid = ($urandom % 3) != 0; lsu_rd = 5'($urandom_range(0, 7)); lsu_wd = $urandom;
         end
         issue_valid = ($urandom % 2) != 0;
         issue_rd = 5'($urandom_range(0, 7));
         issue_rs1 = 5'($urandom_range(0, 7));
         issue_rs2 = 5'($urandom_range(0, 7));
         #1;
         e_stall = issue_valid && (pend[issue_rs1] || pend[issue_rs2] || pend[issue_rd]);
         if (alu_valid && lsu_valid) begin
            g_alu = lsu_won_last; g_lsu = !lsu_won_last;
         end else begin
            g_alu = alu_valid; g_lsu = lsu_valid;
         end
         n_checks++; if (issue_stall !== e_stall) begin
            n_errors++; $display("FAIL rnd_stall c%0d got %b want %b", c, issue_stall, e_stall);
         end
         n_checks++; if (alu_ready !== g_alu || lsu_ready !== g_lsu) begin
            n_errors++; $display("FAIL rnd_grant c%0d got %b%b want %b%b", c, alu_ready, lsu_ready, g_alu, g_lsu);
         end
         e_wen = 1'b0;
         e_a3 = '0;
         e_wd = '0;
         if (g_alu || g_lsu) begin
            lsu_won_last = g_lsu;
            w_rd = g_lsu ? lsu_rd : alu_rd;
            if (w_rd != 0) begin
               if (!pend[w_rd]) err_m = 1'b1;
               pend[w_rd] = 1'b0;
               e_wen = 1'b1; e_a3 = w_rd; e_wd = g_lsu ? lsu_wd : alu_wd;
            end
         end
         if (issue_valid && !e_stall && issue_rd != 0) pend[issue_rd] = 1'b1;
         for (int k = 0; k < 32; k++) e_busy[k] = pend[k];
         alu_done = g_alu; lsu_done = g_lsu;
         tick();
         n_checks++; if (rf_wen !== e_wen || (e_wen && (rf_a3 !== e_a3 || rf_wd !== e_wd))) begin
            n_errors++; $display("FAIL rnd_port c%0d got %b/%0d/%h want %b/%0d/%h", c, rf_wen, rf_a3, rf_wd, e_wen, e_a3, e_wd);
         end
         n_checks++; if (busy !== e_busy) begin
            n_errors++; $display("FAIL rnd_busy c%0d got %h want %h", c, busy, e_busy);
         end
         n_checks++; if (wb_err !== err_m) begin
            n_errors++; $display("FAIL rnd_err c%0d got %b want %b", c, wb_err, err_m);
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      #2;
      test_reset();
      test_raw_stall();
      test_tie_rr();
      test_set_wins();
      test_rd0();
      test_wb_err();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_scheduler.md
REGFILE_SCHEDULER -- requirements
Module: regfile_scheduler

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 issue_valid  in  1  decode presents an instruction.
REQ-005 issue_rd / issue_rs1 / issue_rs2  in  5 each  destination and source register addresses.
REQ-006 issue_stall  out  1  issue not accepted this cycle.
REQ-007 alu_valid / alu_rd / alu_wd  in  1 / 5 / 32  ALU writeback request, address, data.
REQ-008 alu_ready  out  1  ALU request granted this cycle.
REQ-009 lsu_valid / lsu_rd / lsu_wd  in  1 / 5 / 32  load-unit writeback request, address, data.
REQ-010 lsu_ready  out  1  LSU request granted this cycle.
REQ-011 rf_wen / rf_a3 / rf_wd  out  1 / 5 / 32  registered drive of the register file write port.
REQ-012 busy  out  32  scoreboard; bit n set means x_n has a pending write.
REQ-013 wb_err  out  1  sticky flag: writeback to a non-busy register.

Function
REQ-014 Issue accept = issue_valid && !issue_stall; stall is combinational from registered busy: issue_valid && (busy[rs1] | busy[rs2] | busy[rd]).
REQ-015 A writeback clearing busy[x] in cycle N does not release a stall on x until cycle N+1 (no same-cycle bypass).
REQ-016 Issue accept with rd != 0 sets busy[rd] at the next edge; rd == 0 sets nothing.
REQ-017 busy[0] is constant 0.
REQ-018 Arbitration between ALU and LSU is two-way round-robin with a 1-bit last_grant state (ALU=0, LSU=1).
REQ-019 Only one requester valid: it is granted. Both valid: the one not equal to last_grant is granted, and last_grant updates to the winner. Neither valid: last_grant holds.
REQ-020 ready is combinational and asserted only for the granted requester; a transfer is valid && ready.
REQ-021 A granted transfer drives rf_wen=1, rf_a3=rd, rf_wd=wd at the next edge (1-cycle latency). rf_wen=0 in any cycle with no transfer.
REQ-022 A granted transfer with rd == 0 is accepted and rf_wen stays 0.
REQ-023 A granted transfer clears busy[rd] at the next edge.
REQ-024 If an issue sets and a writeback clears the same register in one cycle, set wins and the bit stays 1.
REQ-025 A granted transfer to rd != 0 whose busy bit is 0 still writes and sets wb_err; wb_err clears only on reset.
REQ-026 A requester holding valid without ready keeps rd and wd stable; the block does not check this.

Reset
REQ-027 While rst_n is 0: busy=0, rf_wen=0, rf_a3=0, rf_wd=0, wb_err=0, last_grant=LSU (so ALU wins the first tie).
REQ-028 Reset mid-operation discards all pending busy bits and any in-flight registered write; there is no write on the edge after deassertion.
REQ-029 issue_stall, alu_ready and lsu_ready follow the combinational rules during reset, using the reset state values.

Structure
REQ-030 Shared package rf_sched_pkg holds XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and a grant_e enum {GNT_ALU, GNT_LSU}.
REQ-031 The round-robin arbiter is the sub-module wb_rr_arbiter2 (valid pair in, grant pair out, last_grant state inside).
REQ-032 The scoreboard and the write-port output register are in regfile_scheduler.

Verification
REQ-033 Issue rd=5 accepted, then issue rs1=5 -> second issue stalls. ALU writes x5=0xDEADBEEF -> next cycle rf_wen=1, a3=5, wd=0xDEADBEEF. Stall drops the cycle after the grant, not in the grant cycle.
REQ-034 ALU and LSU valid together for 4 cycles after reset -> grants ALU, LSU, ALU, LSU; rf_a3 follows the same order one cycle later.
REQ-035 Issue rd=7 and LSU writeback rd=7 in the same cycle -> busy[7]=1 afterwards; rf_wen=1 with a3=7.
REQ-036 ALU writeback rd=0 wd=0x1234 -> alu_ready=1, rf_wen stays 0, busy unchanged, wb_err=0.
REQ-037 LSU writeback rd=9 with busy[9]=0 -> write occurs and wb_err=1, which stays 1 until rst_n is asserted.
REQ-038 busy=0x0000_0F00 with a write pending, assert rst_n=0 asynchronously -> busy=0 and rf_wen=0 immediately; no write after release.
